// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder: default geometry,
// MMIO register offsets relative to MMIO_BASE and STATUS bit positions.
package dmem_responder_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MMIO_BASE  = 'hF0;
  localparam int DEF_FIFO_DEPTH = 4;

  localparam int REG_CONSOLE_DATA = 0;
  localparam int REG_STATUS       = 1;
  localparam int REG_CYCLE_LO     = 2;
  localparam int REG_CYCLE_HI     = 3;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVF   = 2;

  localparam int CYCLE_WIDTH = 16;

endpackage

// File: rtl/dmem_responder_if.sv
// CPU data-memory bus plus the console output stream, bundled so the
// responder and its surroundings share one port list.
interface dmem_responder_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);

  logic [ADDR_WIDTH-1:0] dmem_addr;
  logic                  dmem_wenable;
  logic [DATA_WIDTH-1:0] dmem_wvalue;
  logic [DATA_WIDTH-1:0] dmem_rvalue;
  logic [DATA_WIDTH-1:0] cons_data;
  logic                  cons_valid;
  logic                  cons_ready;

  modport master (
    output dmem_addr, dmem_wenable, dmem_wvalue, cons_ready,
    input  dmem_rvalue, cons_data, cons_valid
  );

  modport slave (
    input  dmem_addr, dmem_wenable, dmem_wvalue, cons_ready,
    output dmem_rvalue, cons_data, cons_valid
  );

endinterface

// File: rtl/dmem_responder_console_fifo.sv
// Console TX FIFO: registered storage, no bypass, and a push that is still
// accepted when full provided the head leaves on the same edge.
module console_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  push_ok,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  empty,
  output logic                  full
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_pop_ok;

  assign empty    = (r_count == '0);
  assign full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop_ok = pop && !empty;
  assign push_ok  = push && (!full || w_pop_ok);
  assign head     = empty ? '0 : r_mem[r_rd_ptr];

  // When full, the write slot equals the head slot; the head is read
  // combinationally, so the popped byte leaves before being overwritten.
  always_ff @(posedge clock) begin
    if (nreset && push_ok) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Slave end of the CPU data-memory bus: RAM below MMIO_BASE, console FIFO,
// STATUS with sticky overflow, and a free-running cycle counter snapshot.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MMIO_BASE  = DEF_MMIO_BASE,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input logic             clock,
  input logic             nreset,
  dmem_responder_if.slave bus
);

  logic [DATA_WIDTH-1:0]  r_ram [MMIO_BASE];
  logic [CYCLE_WIDTH-1:0] r_cycle;
  logic [CYCLE_WIDTH-1:0] r_snapshot;
  logic                   r_overflow;

  logic                  w_wr_en;
  logic                  w_is_ram;
  logic [ADDR_WIDTH-1:0] w_offset;
  logic                  w_sel_cons;
  logic                  w_sel_status;
  logic                  w_sel_cyc_lo;
  logic                  w_push;
  logic                  w_push_ok;
  logic                  w_empty;
  logic                  w_full;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_wr_en      = bus.dmem_wenable && nreset;
  assign w_is_ram     = (bus.dmem_addr < ADDR_WIDTH'(MMIO_BASE));
  assign w_offset     = bus.dmem_addr - ADDR_WIDTH'(MMIO_BASE);
  assign w_sel_cons   = !w_is_ram && (w_offset == ADDR_WIDTH'(REG_CONSOLE_DATA));
  assign w_sel_status = !w_is_ram && (w_offset == ADDR_WIDTH'(REG_STATUS));
  assign w_sel_cyc_lo = !w_is_ram && (w_offset == ADDR_WIDTH'(REG_CYCLE_LO));
  assign w_push       = w_wr_en && w_sel_cons;

  console_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_console_fifo (
    .clock     (clock),
    .nreset    (nreset),
    .push      (w_push),
    .push_data (bus.dmem_wvalue),
    .push_ok   (w_push_ok),
    .pop       (bus.cons_ready),
    .head      (bus.cons_data),
    .empty     (w_empty),
    .full      (w_full)
  );

  assign bus.cons_valid = !w_empty;

  // RAM survives reset; only writes presented while out of reset land.
  always_ff @(posedge clock) begin
    if (w_wr_en && w_is_ram) begin
      r_ram[bus.dmem_addr] <= bus.dmem_wvalue;
    end
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_cycle    <= '0;
      r_snapshot <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 1'b1;
      if (w_wr_en && w_sel_cyc_lo) begin
        r_snapshot <= r_cycle;
      end
      if (w_wr_en && w_sel_status && bus.dmem_wvalue[STAT_OVF]) begin
        r_overflow <= 1'b0;
      end else if (w_push && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_is_ram) begin
      w_rdata = r_ram[bus.dmem_addr];
    end else begin
      case (w_offset)
        ADDR_WIDTH'(REG_STATUS): begin
          w_rdata[STAT_EMPTY] = w_empty;
          w_rdata[STAT_FULL]  = w_full;
          w_rdata[STAT_OVF]   = r_overflow;
        end
        ADDR_WIDTH'(REG_CYCLE_LO): w_rdata = DATA_WIDTH'(r_snapshot[7:0]);
        ADDR_WIDTH'(REG_CYCLE_HI): w_rdata = DATA_WIDTH'(r_snapshot[15:8]);
        default:                   w_rdata = '0;
      endcase
    end
  end

  assign bus.dmem_rvalue = w_rdata;

endmodule
